datapath: RTL and testbench

32-bit single-bus CPU datapath: register file, special registers, a 64-bit-result ALU and a shared bus. An external control unit drives it, or a bench in this phase of the CPU bring-up. Each control line selects one bus source, loads one or more registers on the rising clock edge, or chooses the ALU operation. Memory is represented by the `Mdatain` input word.

---
 rtl/datapath_pkg.sv | 33 +++
 rtl/datapath_alu.sv | 57 +++++
 rtl/datapath.sv | 90 +++++++++
 tb/tb_datapath.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: data width, ALU opcodes
// and bus-source indices (lower index wins the bus).
package datapath_pkg;
    localparam int DW = 32;
    localparam int NUM_REGS = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int SEL_R0  = 0;
    localparam int SEL_HI  = 16;
    localparam int SEL_LO  = 17;
    localparam int SEL_ZHI = 18;
    localparam int SEL_ZLO = 19;
    localparam int SEL_PC  = 20;
    localparam int SEL_MDR = 21;
    localparam int SEL_C   = 22;
    localparam int NUM_SEL = 23;
endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result destined for Z.
// Multiply/divide exist only when DATAPATH_MULDIV_EN is defined.
module alu
    import datapath_pkg::*;
(
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [4:0]      opcode,
    input  logic            inc_pc,
    output logic [2*DW-1:0] result
);
    logic [4:0]      sh;
    logic [2*DW-1:0] rol_w, ror_w;

    assign sh = b[4:0];
    // Rotates fall out of shifting a doubled copy of A.
    assign rol_w = {a, a} << sh;
    assign ror_w = {a, a} >> sh;

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*DW-1:0] prod;
    logic signed [DW-1:0]   quo, rem;

    assign prod = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    assign quo  = $signed(a) / $signed(b);
    assign rem  = $signed(a) % $signed(b);
`endif

    always_comb begin
        result = '0;
        if (inc_pc) begin
            result[DW-1:0] = b + 32'd1;
        end else begin
            case (opcode)
                OP_ADD, OP_ADDI: result[DW-1:0] = a + b;
                OP_SUB:          result[DW-1:0] = a - b;
                OP_AND, OP_ANDI: result[DW-1:0] = a & b;
                OP_OR, OP_ORI:   result[DW-1:0] = a | b;
                OP_SHR:          result[DW-1:0] = a >> sh;
                OP_SHRA:         result[DW-1:0] = $signed(a) >>> sh;
                OP_SHL:          result[DW-1:0] = a << sh;
                OP_ROR:          result[DW-1:0] = ror_w[DW-1:0];
                OP_ROL:          result[DW-1:0] = rol_w[2*DW-1:DW];
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:          result = prod;
                // Divide by zero: remainder = A, quotient = all ones.
                OP_DIV:          result = (b == '0) ? {a, {DW{1'b1}}} : {rem, quo};
`else
                OP_MUL, OP_DIV:  result = '0;
`endif
                OP_NEG:          result[DW-1:0] = 32'd0 - b;
                OP_NOT:          result[DW-1:0] = ~b;
                default:         result[DW-1:0] = b;
            endcase
        end
    end
endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC/MAR/MDR/Y/HI/LO, 64-bit Z, ALU.
// Optional mul/div via DATAPATH_MULDIV_EN. bus and mar are exported for memory/observation.
module datapath
    import datapath_pkg::*;
(
    input  logic          Clock,
    input  logic          clear,
    input  logic [DW-1:0] Mdatain,
    input  logic          Read,
    input  logic          IncPC,
    input  logic [15:0]   Rin,
    input  logic [15:0]   Rout,
    input  logic          PCin,
    input  logic          Zin,
    input  logic          MDRin,
    input  logic          MARin,
    input  logic          Yin,
    input  logic          HIin,
    input  logic          LOin,
    input  logic          PCout,
    input  logic          Zhighout,
    input  logic          Zlowout,
    input  logic          HIout,
    input  logic          LOout,
    input  logic          MDRout,
    input  logic          Cout,
    input  logic [4:0]    opcode,
    output logic [DW-1:0] bus,
    output logic [DW-1:0] mar
);
    logic [NUM_REGS-1:0][DW-1:0] regs;
    logic [DW-1:0]               pc, mdr, y, hi, lo;
    logic [2*DW-1:0]             z, alu_result;
    logic [NUM_SEL-1:0]          sel;
    logic [NUM_SEL-1:0][DW-1:0]  src;

    assign sel = {Cout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};

    always_comb begin
        src = '0;
        for (int i = 0; i < NUM_REGS; i++) src[SEL_R0+i] = regs[i];
        src[SEL_HI]  = hi;
        src[SEL_LO]  = lo;
        src[SEL_ZHI] = z[2*DW-1:DW];
        src[SEL_ZLO] = z[DW-1:0];
        src[SEL_PC]  = pc;
        src[SEL_MDR] = mdr;
        src[SEL_C]   = {{(DW-19){mdr[18]}}, mdr[18:0]};
    end

    // Scan from the lowest-priority source up so the lowest asserted index wins.
    always_comb begin
        bus = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (sel[i]) bus = src[i];
        end
    end

    alu u_alu (
        .a      (y),
        .b      (bus),
        .opcode (opcode),
        .inc_pc (IncPC),
        .result (alu_result)
    );

    always_ff @(posedge Clock) begin
        if (clear) begin
            regs <= '0;
            pc   <= '0;
            mar  <= '0;
            mdr  <= '0;
            y    <= '0;
            hi   <= '0;
            lo   <= '0;
            z    <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (Rin[i]) regs[i] <= bus;
            end
            if (PCin)  pc  <= bus;
            if (MARin) mar <= bus;
            if (MDRin) mdr <= Read ? Mdatain : bus;
            if (Yin)   y   <= bus;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (Zin)   z   <= alu_result;
        end
    end
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed bring-up sequence plus randomized
// control words checked against a behavioural model of registers, bus and ALU.
module tb_datapath;
    logic        Clock = 1'b0;
    logic        clear, Read, IncPC;
    logic [31:0] Mdatain;
    logic [15:0] Rin, Rout;
    logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
    logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
    logic [4:0]  opcode;
    logic [31:0] bus, mar;

    int passes = 0;
    int total  = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_mar, m_mdr, m_y, m_hi, m_lo;
    logic [63:0] m_z;

    datapath dut (
        .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
        .opcode(opcode), .bus(bus), .mar(mar)
    );

    always #5 Clock = ~Clock;

    task automatic idle();
        clear = 0; Read = 0; IncPC = 0; Rin = '0; Rout = '0; opcode = '0;
        PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
        PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
    endtask

    // Bench source numbering: 0-15 Rn, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 C, 23 none.
    task automatic set_sel(input int s);
        if (s < 16) Rout[s] = 1'b1;
        else case (s)
            16: HIout = 1; 17: LOout = 1; 18: Zhighout = 1; 19: Zlowout = 1;
            20: PCout = 1; 21: MDRout = 1; 22: Cout = 1;
            default: ;
        endcase
    endtask

    task automatic show(input int s);
        idle();
        set_sel(s);
        #1;
    endtask

    function automatic logic [31:0] m_bus();
        for (int i = 0; i < 16; i++) if (Rout[i]) return m_r[i];
        if (HIout)    return m_hi;
        if (LOout)    return m_lo;
        if (Zhighout) return m_z[63:32];
        if (Zlowout)  return m_z[31:0];
        if (PCout)    return m_pc;
        if (MDRout)   return m_mdr;
        if (Cout)     return m_mdr[18] ? (m_mdr | 32'hFFF8_0000) : (m_mdr & 32'h0007_FFFF);
        return 32'h0;
    endfunction

    function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op, input logic inc);
        longint sa, sb, q, r;
        int s;
        logic [63:0] aa;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b % 32);
        aa = {a, a};
        if (inc) return {32'h0, b + 32'h1};
        case (op)
            5'd3, 5'd12: return {32'h0, a + b};
            5'd4:        return {32'h0, a - b};
            5'd5, 5'd13: return {32'h0, a & b};
            5'd6, 5'd14: return {32'h0, a | b};
            5'd7:        return {32'h0, a >> s};
            5'd8:        return {32'h0, 32'(sa >>> s)};
            5'd9:        return {32'h0, a << s};
            5'd10:       return {32'h0, 32'(aa >> s)};
            5'd11:       return {32'h0, 32'((aa << s) >> 32)};
`ifdef DATAPATH_MULDIV_EN
            5'd15:       return 64'(sa * sb);
            5'd16: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
`else
            5'd15, 5'd16: return 64'h0;
`endif
            5'd17:       return {32'h0, 32'h0 - b};
            5'd18:       return {32'h0, ~b};
            default:     return {32'h0, b};
        endcase
    endfunction

    // Apply the current control word for one rising edge, to both DUT and model.
    task automatic tick();
        logic [31:0] b;
        logic [63:0] zr;
        b  = m_bus();
        zr = m_alu(m_y, b, opcode, IncPC);
        @(posedge Clock);
        if (clear) begin
            for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
            m_pc = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_hi = 0; m_lo = 0; m_z = 0;
        end else begin
            for (int i = 0; i < 16; i++) if (Rin[i]) m_r[i] = b;
            if (PCin)  m_pc  = b;
            if (MARin) m_mar = b;
            if (MDRin) m_mdr = Read ? Mdatain : b;
            if (Yin)   m_y   = b;
            if (HIin)  m_hi  = b;
            if (LOin)  m_lo  = b;
            if (Zin)   m_z   = zr;
        end
        #1;
    endtask

    task automatic load_reg(input int rn, input logic [31:0] v);
        idle(); Mdatain = v; Read = 1; MDRin = 1; tick();
        idle(); MDRout = 1; Rin[rn] = 1; tick();
    endtask

    task automatic test_reset();
        idle(); Mdatain = 32'hDEAD_BEEF; Rin = 16'hFFFF; PCin = 1; Zin = 1; clear = 1; tick();
        for (int s = 0; s < 23; s++) begin
            show(s); total++;
            if (bus !== 32'h0) $display("FAIL reset_src%0d: got %h want %h", s, bus, 32'h0); else passes++;
        end
        show(23); total++;
        if (bus !== 32'h0) $display("FAIL reset_nosel: got %h want %h", bus, 32'h0); else passes++;
        total++;
        if (mar !== 32'h0) $display("FAIL reset_mar: got %h want %h", mar, 32'h0); else passes++;
        idle(); opcode = 5'd3; Zin = 1; tick();
        show(19); total++;
        if (bus !== 32'h0) $display("FAIL reset_y: got %h want %h", bus, 32'h0); else passes++;
    endtask

    task automatic test_ops();
        load_reg(3, 32'h12);
        show(3); total++;
        if (bus !== 32'h12) $display("FAIL load_r3: got %h want %h", bus, 32'h12); else passes++;
        load_reg(5, 32'h14);
        show(5); total++;
        if (bus !== 32'h14) $display("FAIL load_r5: got %h want %h", bus, 32'h14); else passes++;
        idle(); Rout = 16'hFFF8; HIout = 1; Cout = 1; #1; total++;
        if (bus !== 32'h12) $display("FAIL bus_priority: got %h want %h", bus, 32'h12); else passes++;
        idle(); Rout[3] = 1; Yin = 1; tick();
        idle(); Rout[5] = 1; opcode = 5'b00011; Zin = 1; tick();
        show(19); total++;
        if (bus !== 32'h26) $display("FAIL add_lo: got %h want %h", bus, 32'h26); else passes++;
        idle(); Rout[5] = 1; opcode = 5'b00100; Zin = 1; tick();
        show(19); total++;
        if (bus !== 32'hFFFF_FFFE) $display("FAIL sub_lo: got %h want %h", bus, 32'hFFFF_FFFE); else passes++;
        show(18); total++;
        if (bus !== 32'h0) $display("FAIL sub_hi: got %h want %h", bus, 32'h0); else passes++;
        idle(); Rout[5] = 1; opcode = 5'b00111; Zin = 1; tick();
        idle(); Zlowout = 1; Rin[1] = 1; tick();
        show(1); total++;
        if (bus !== 32'h0) $display("FAIL shr20: got %h want %h", bus, 32'h0); else passes++;
        load_reg(5, 32'h2);
        idle(); Rout[5] = 1; opcode = 5'b00111; Zin = 1; tick();
        idle(); Zlowout = 1; Rin[1] = 1; tick();
        show(1); total++;
        if (bus !== 32'h4) $display("FAIL shr2: got %h want %h", bus, 32'h4); else passes++;
        idle(); Mdatain = 32'h0004_0000; Read = 1; MDRin = 1; tick();
        show(22); total++;
        if (bus !== 32'hFFFC_0000) $display("FAIL c_signext: got %h want %h", bus, 32'hFFFC_0000); else passes++;
    endtask

    task automatic test_incpc();
        idle(); PCout = 1; MARin = 1; IncPC = 1; opcode = 5'b00100; Zin = 1; tick();
        total++;
        if (mar !== 32'h0) $display("FAIL incpc_mar: got %h want %h", mar, 32'h0); else passes++;
        show(19); total++;
        if (bus !== 32'h1) $display("FAIL incpc_zlo: got %h want %h", bus, 32'h1); else passes++;
        show(18); total++;
        if (bus !== 32'h0) $display("FAIL incpc_zhi: got %h want %h", bus, 32'h0); else passes++;
        idle(); Zlowout = 1; PCin = 1; tick();
        show(20); total++;
        if (bus !== 32'h1) $display("FAIL incpc_pc: got %h want %h", bus, 32'h1); else passes++;
    endtask

    task automatic test_muldiv();
        logic [31:0] e_mhi, e_mlo, e_dhi, e_dlo, e_zhi, e_zlo;
`ifdef DATAPATH_MULDIV_EN
        e_mhi = 32'hFFFF_FFFF; e_mlo = 32'hFFFF_FFF4; e_dhi = 32'h1; e_dlo = 32'h3;
        e_zhi = 32'h7; e_zlo = 32'hFFFF_FFFF;
`else
        e_mhi = 0; e_mlo = 0; e_dhi = 0; e_dlo = 0; e_zhi = 0; e_zlo = 0;
`endif
        load_reg(6, 32'h6);
        idle(); Rout[6] = 1; Yin = 1; tick();
        idle(); Mdatain = 32'hFFFF_FFFE; Read = 1; MDRin = 1; tick();
        idle(); MDRout = 1; opcode = 5'b01111; Zin = 1; tick();
        show(18); total++;
        if (bus !== e_mhi) $display("FAIL mul_hi: got %h want %h", bus, e_mhi); else passes++;
        show(19); total++;
        if (bus !== e_mlo) $display("FAIL mul_lo: got %h want %h", bus, e_mlo); else passes++;
        load_reg(6, 32'h7);
        idle(); Rout[6] = 1; Yin = 1; tick();
        load_reg(7, 32'h2);
        idle(); Rout[7] = 1; opcode = 5'b10000; Zin = 1; tick();
        idle(); Zhighout = 1; HIin = 1; tick();
        idle(); Zlowout = 1; LOin = 1; tick();
        show(16); total++;
        if (bus !== e_dhi) $display("FAIL div_hi_reg: got %h want %h", bus, e_dhi); else passes++;
        show(17); total++;
        if (bus !== e_dlo) $display("FAIL div_lo_reg: got %h want %h", bus, e_dlo); else passes++;
        idle(); opcode = 5'b10000; Zin = 1; tick();
        show(18); total++;
        if (bus !== e_zhi) $display("FAIL div0_hi: got %h want %h", bus, e_zhi); else passes++;
        show(19); total++;
        if (bus !== e_zlo) $display("FAIL div0_lo: got %h want %h", bus, e_zlo); else passes++;
    endtask

    task automatic test_clear_midrun();
        idle(); Rout[3] = 1; opcode = 5'b00011; Zin = 1; tick();
        idle(); clear = 1; Rout[3] = 1; Rin = 16'hFFFF; PCin = 1; Zin = 1; Yin = 1; tick();
        show(1); total++;
        if (bus !== 32'h0) $display("FAIL clear_r1: got %h want %h", bus, 32'h0); else passes++;
        show(20); total++;
        if (bus !== 32'h0) $display("FAIL clear_pc: got %h want %h", bus, 32'h0); else passes++;
        show(19); total++;
        if (bus !== 32'h0) $display("FAIL clear_zlo: got %h want %h", bus, 32'h0); else passes++;
        show(23); total++;
        if (bus !== 32'h0) $display("FAIL clear_nosel: got %h want %h", bus, 32'h0); else passes++;
    endtask

    task automatic test_random();
        int s;
        logic [31:0] exp;
        for (int n = 0; n < 400; n++) begin
            idle();
            Mdatain = $urandom;
            Read    = 1'($urandom_range(0, 1));
            IncPC   = ($urandom_range(0, 7) == 0);
            opcode  = 5'($urandom_range(0, 31));
            clear   = ($urandom_range(0, 49) == 0);
            Rin     = 16'($urandom) & 16'($urandom) & 16'($urandom);
            {PCin, Zin, MDRin, MARin, Yin, HIin, LOin} = 7'($urandom) & 7'($urandom);
            set_sel($urandom_range(0, 23));
            if ($urandom_range(0, 3) == 0) set_sel($urandom_range(0, 22));
            #1;
            exp = m_bus(); total++;
            if (bus !== exp) $display("FAIL rnd_bus n=%0d: got %h want %h", n, bus, exp); else passes++;
            tick();
            s = $urandom_range(0, 22);
            show(s);
            exp = m_bus(); total++;
            if (bus !== exp) $display("FAIL rnd_src%0d n=%0d: got %h want %h", s, n, bus, exp); else passes++;
            total++;
            if (mar !== m_mar) $display("FAIL rnd_mar n=%0d: got %h want %h", n, mar, m_mar); else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
        m_pc = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_hi = 0; m_lo = 0; m_z = 0;
        Mdatain = 0;
        idle();
        test_reset();
        test_ops();
        test_incpc();
        test_muldiv();
        test_clear_midrun();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
